// File: rtl/fp_norm_round.sv
// fp_norm_round: renormalise, round-to-nearest-even and pack the adder's raw mantissa sum.
// Carry is fixed by one right shift; leading zeros take up to STEP bits per NORM cycle.
module fp_norm_round #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d, pk_q, pk_d, found, up;
    logic [26:0] m_q, m_d;
    logic [9:0]  e_q, e_d, sh, re;
    logic [31:0] res_q, res_d;
    logic [4:0]  lz;
    logic [24:0] top;
    logic [23:0] rm;

    always_comb begin
        lz = 5'd26;
        found = 1'b0;
        for (int i = 25; i >= 0; i--) begin
            if (!found && m_q[i]) begin
                lz = 5'(25 - i);
                found = 1'b1;
            end
        end
        sh = 10'(STEP);
        sh = ({5'b0, lz} < sh) ? {5'b0, lz} : sh;
        sh = ((e_q - 10'd1) < sh) ? e_q - 10'd1 : sh;
        up = m_q[1] & (m_q[0] | m_q[2]);
        top = m_q[26:2] + {24'b0, up};
        // A rounding carry into bit 26 renormalises by one and bumps the exponent.
        rm = top[24] ? top[24:1] : top[23:0];
        re = e_q + {9'b0, top[24]};
    end

    always_comb begin
        state_d = state_q;
        sign_d = sign_q;
        m_d = m_q;
        e_d = e_q;
        res_d = res_q;
        pk_d = pk_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d = in_sign;
                m_d = in_mant;
                e_d = (in_exp == 8'd0) ? 10'd1 : {2'b0, in_exp};
                pk_d = (in_exp == 8'hFF);
                res_d = (in_exp == 8'hFF) ? {in_sign, 8'hFF, in_mant[24:2]} : res_q;
                state_d = NORM;
            end
            NORM: begin
                if (pk_q) begin
                    state_d = DONE;
                end else if (m_q == 27'd0) begin
                    res_d = {sign_q, 31'b0};
                    state_d = DONE;
                end else if (m_q[26]) begin
                    m_d = {1'b0, m_q[26:2], m_q[1] | m_q[0]};
                    e_d = e_q + 10'd1;
                    state_d = ROUND;
                end else if (m_q[25] || e_q == 10'd1) begin
                    state_d = ROUND;
                end else begin
                    m_d = m_q << sh;
                    e_d = e_q - sh;
                end
            end
            ROUND: begin
                res_d = (re >= 10'd255) ? {sign_q, 8'hFF, 23'b0}
                                        : {sign_q, rm[23] ? re[7:0] : 8'h00, rm[22:0]};
                state_d = DONE;
            end
            default: state_d = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q <= 1'b0;
            pk_q <= 1'b0;
            m_q <= 27'd0;
            e_q <= 10'd1;
            res_q <= 32'd0;
        end else begin
            state_q <= state_d;
            sign_q <= sign_d;
            pk_q <= pk_d;
            m_q <= m_d;
            e_q <= e_d;
            res_q <= res_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_result = res_q;
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: vector table plus scoreboard queue for fp_norm_round (STEP=4),
// including backpressure hold and asynchronous reset during normalisation.
module tb_fp_norm_round;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [26:0] in_mant = 27'd0;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    int          pass_cnt = 0, total_cnt = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic [26:0] mant;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vecs[16];

    fp_norm_round #(.STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic run_op(input vec_t v, input int hold);
        int n;
        logic [31:0] e;
        @(negedge clk);
        in_sign = v.sign;
        in_exp = v.ex;
        in_mant = v.mant;
        in_valid = 1'b1;
        sb.push_back(v.res);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 60);
        chk($sformatf("latency mant=%h exp=%0d", v.mant, v.ex), n, v.lat);
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        chk($sformatf("result mant=%h exp=%0d", v.mant, v.ex), out_result, e);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_mant = 27'h4000000;
            in_exp = 8'd3;
            @(negedge clk);
            chk("hold result stable", out_result, e);
            chk("hold in_ready low", {31'b0, in_ready}, 32'd0);
            chk("hold out_valid high", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("out_valid drops after handshake", {31'b0, out_valid}, 32'd0);
        chk("in_ready after handshake", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'd127, 27'h2000000, 32'h3F800000, 3};
        vecs[1]  = '{1'b0, 8'd127, 27'h4000000, 32'h40000000, 3};
        vecs[2]  = '{1'b0, 8'd127, 27'h0000004, 32'h34000000, 9};
        vecs[3]  = '{1'b0, 8'd127, 27'h2000006, 32'h3F800002, 3};
        vecs[4]  = '{1'b0, 8'd127, 27'h2000002, 32'h3F800000, 3};
        vecs[5]  = '{1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 3};
        vecs[6]  = '{1'b0, 8'd254, 27'h4000000, 32'h7F800000, 3};
        vecs[7]  = '{1'b0, 8'd1,   27'h0800000, 32'h00200000, 3};
        vecs[8]  = '{1'b1, 8'd127, 27'h0000000, 32'h80000000, 2};
        vecs[9]  = '{1'b0, 8'd255, 27'h2000004, 32'h7F800001, 2};
        vecs[10] = '{1'b0, 8'd0,   27'h0800000, 32'h00200000, 3};
        vecs[11] = '{1'b1, 8'd127, 27'h2000000, 32'hBF800000, 3};
        vecs[12] = '{1'b0, 8'd1,   27'h1FFFFFE, 32'h00800000, 3};
        vecs[13] = '{1'b0, 8'd3,   27'h0000400, 32'h00000400, 4};
        vecs[14] = '{1'b0, 8'd10,  27'h0800000, 32'h04000000, 4};
        vecs[15] = '{1'b0, 8'd128, 27'h2000005, 32'h40000001, 3};

        #2;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_op(vecs[i], 0);

        run_op(vecs[0], 5);

        @(negedge clk);
        in_exp = 8'd127;
        in_mant = 27'h0000004;
        in_sign = 1'b0;
        in_valid = 1'b1;
        sb.push_back(32'h34000000);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid-NORM reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid-NORM reset in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[5], 0);
        run_op(vecs[2], 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
